// File: rtl/oled_spi_engine.sv
// oled_spi_engine: SSD1331 PMOD OLED front end. Runs an external init ROM
// after reset, then arbitrates window-setup, buffered raw bytes and streamed
// pixels onto a single mode-0 SPI bus.
module oled_spi_engine #(
  parameter int SYSTEM_CLK        = 50_000_000,
  parameter int SPI_TRANSFER_RATE = 25_000_000,
  parameter int FIFO_DEPTH        = 16,
  parameter int PIXEL_BYTES       = 2,
  parameter int INIT_LEN          = 45,
  parameter int RST_HOLD_CYCLES   = 16,
  parameter int CS_GAP_CYCLES     = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  output logic [$clog2(INIT_LEN)-1:0]   init_rom_addr,
  input  logic [7:0]                    init_rom_data,
  input  logic                          win_valid,
  output logic                          win_ready,
  input  logic [7:0]                    win_x0,
  input  logic [7:0]                    win_x1,
  input  logic [7:0]                    win_y0,
  input  logic [7:0]                    win_y1,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_dc,
  input  logic [7:0]                    cmd_data,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [8*PIXEL_BYTES-1:0]      pix_data,
  output logic                          init_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          spi_cs,
  output logic                          spi_dc,
  output logic                          spi_mosi,
  output logic                          spi_sck,
  output logic                          oled_rst,
  output logic                          vccen,
  output logic                          pmoden
);

  // Clock cycles per SCK phase, never below one.
  localparam int HALF_RAW = SYSTEM_CLK / SPI_TRANSFER_RATE / 2;
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int HW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int AW       = $clog2(INIT_LEN);
  // Byte index must reach INIT_LEN (one past the last ROM address) and 6.
  localparam int IW_RAW   = $clog2(INIT_LEN + 1);
  localparam int IW       = (IW_RAW < 3) ? 3 : IW_RAW;
  localparam int CNT_MAX  = (RST_HOLD_CYCLES > CS_GAP_CYCLES) ? RST_HOLD_CYCLES : CS_GAP_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_INIT,
    S_IDLE,
    S_WIN,
    S_RAW,
    S_PIX,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            byte_idx_q, byte_idx_d;
  logic                     init_done_q, init_done_d;
  logic                     oled_rst_q, oled_rst_d;
  logic                     vccen_q, vccen_d;
  logic [7:0]               x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [8*PIXEL_BYTES-1:0] pix_q, pix_d;
  logic                     alive_q;

  // ---------------------------------------------------------------------------
  // Byte shifter state
  // ---------------------------------------------------------------------------
  logic          active_q, active_d;
  logic          sck_q, sck_d;
  logic [HW-1:0] half_q, half_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          dc_q, dc_d;
  logic          cs_q, cs_d;

  // FSM-to-shifter handshake
  logic       load;
  logic [7:0] load_byte;
  logic       load_dc;
  logic       stop;
  logic       byte_end;
  logic       step;

  // ---------------------------------------------------------------------------
  // Raw-byte FIFO
  // ---------------------------------------------------------------------------
  logic [8:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;
  logic          fifo_empty, fifo_full;
  logic [8:0]    fifo_head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  // alive_q keeps cmd_ready low while reset is asserted.
  assign cmd_ready  = alive_q && !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign fifo_level = count_q;

  // FIFO storage: write-only port, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {cmd_dc, cmd_data};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte selection helpers
  // ---------------------------------------------------------------------------
  logic [7:0] win_byte;
  logic [7:0] pix_byte [4];

  // Pixel bytes, most significant first; unused slots read as zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pix_byte
    if (gi < PIXEL_BYTES) begin : g_used
      assign pix_byte[gi] = pix_q[8*(PIXEL_BYTES-gi)-1 -: 8];
    end else begin : g_unused
      assign pix_byte[gi] = 8'h00;
    end
  end

  // Window sequence: column address command, bounds, row address command, bounds.
  always_comb begin
    win_byte = 8'h00;
    case (byte_idx_q)
      IW'(0):  win_byte = 8'h15;
      IW'(1):  win_byte = x0_q;
      IW'(2):  win_byte = x1_q;
      IW'(3):  win_byte = 8'h75;
      IW'(4):  win_byte = y0_q;
      IW'(5):  win_byte = y1_q;
      default: win_byte = 8'h00;
    endcase
  end

  // Last SCK-high phase of bit 7: the shifter needs a new byte or a stop.
  assign byte_end = active_q && sck_q && (half_q == HW'(HALF-1)) && (bit_q == 3'd7);
  assign step     = !active_q || byte_end;

  // Next-state logic: sequencing, arbitration and byte sourcing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_idx_d  = byte_idx_q;
    init_done_d = init_done_q;
    oled_rst_d  = oled_rst_q;
    vccen_d     = vccen_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    pix_d       = pix_q;
    load        = 1'b0;
    load_byte   = 8'h00;
    load_dc     = 1'b0;
    stop        = 1'b0;
    pop         = 1'b0;
    win_ready   = 1'b0;
    pix_ready   = 1'b0;

    unique case (state_q)
      S_RST_HOLD: begin
        if (cnt_q == CW'(RST_HOLD_CYCLES - 1)) begin
          cnt_d      = '0;
          oled_rst_d = 1'b1;
          vccen_d    = 1'b1;
          state_d    = S_INIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_INIT: begin
        if (step) begin
          if (byte_idx_q < IW'(INIT_LEN)) begin
            load       = 1'b1;
            load_byte  = init_rom_data;
            byte_idx_d = byte_idx_q + IW'(1);
          end else begin
            stop = 1'b1;
          end
        end
      end

      S_IDLE: begin
        if (init_done_q) begin
          if (win_valid) begin
            win_ready  = 1'b1;
            x0_d       = win_x0;
            x1_d       = win_x1;
            y0_d       = win_y0;
            y1_d       = win_y1;
            byte_idx_d = '0;
            state_d    = S_WIN;
          end else if (!fifo_empty) begin
            state_d = S_RAW;
          end else if (pix_valid) begin
            pix_ready  = 1'b1;
            pix_d      = pix_data;
            byte_idx_d = '0;
            state_d    = S_PIX;
          end
        end
      end

      S_WIN: begin
        if (step) begin
          if (byte_idx_q < IW'(6)) begin
            load       = 1'b1;
            load_byte  = win_byte;
            byte_idx_d = byte_idx_q + IW'(1);
          end else begin
            stop = 1'b1;
          end
        end
      end

      S_RAW: begin
        if (step) begin
          if (!fifo_empty) begin
            load      = 1'b1;
            load_byte = fifo_head[7:0];
            load_dc   = fifo_head[8];
            pop       = 1'b1;
          end else begin
            stop = 1'b1;
          end
        end
      end

      S_PIX: begin
        if (step) begin
          if (byte_idx_q < IW'(PIXEL_BYTES)) begin
            load       = 1'b1;
            load_byte  = pix_byte[byte_idx_q[1:0]];
            load_dc    = 1'b1;
            byte_idx_d = byte_idx_q + IW'(1);
          end else if (pix_valid) begin
            // Chain the next pixel straight from the input, no idle cycle.
            pix_ready  = 1'b1;
            pix_d      = pix_data;
            load       = 1'b1;
            load_byte  = pix_data[8*PIXEL_BYTES-1 -: 8];
            load_dc    = 1'b1;
            byte_idx_d = IW'(1);
          end else begin
            stop = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (cnt_q == CW'(CS_GAP_CYCLES - 1)) begin
          cnt_d       = '0;
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_RST_HOLD;
    endcase

    if (stop) begin
      state_d    = S_GAP;
      cnt_d      = '0;
      byte_idx_d = '0;
    end
  end

  // Mode-0 shifter: load drops CS and presents bit 7, SCK toggles every HALF.
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    half_d   = half_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    dc_d     = dc_q;
    cs_d     = cs_q;
    if (load) begin
      active_d = 1'b1;
      shift_d  = load_byte;
      dc_d     = load_dc;
      cs_d     = 1'b0;
      sck_d    = 1'b0;
      half_d   = '0;
      bit_d    = '0;
    end else if (stop) begin
      active_d = 1'b0;
      shift_d  = 8'h00;
      cs_d     = 1'b1;
      sck_d    = 1'b0;
      half_d   = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (half_q == HW'(HALF-1)) begin
        half_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          sck_d   = 1'b0;
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
        end
      end else begin
        half_d = half_q + HW'(1);
      end
    end
  end

  // State registers; reset aborts any byte in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_RST_HOLD;
      cnt_q       <= '0;
      byte_idx_q  <= '0;
      init_done_q <= 1'b0;
      oled_rst_q  <= 1'b0;
      vccen_q     <= 1'b0;
      x0_q        <= 8'h00;
      x1_q        <= 8'h00;
      y0_q        <= 8'h00;
      y1_q        <= 8'h00;
      pix_q       <= '0;
      alive_q     <= 1'b0;
      active_q    <= 1'b0;
      sck_q       <= 1'b0;
      half_q      <= '0;
      bit_q       <= '0;
      shift_q     <= 8'h00;
      dc_q        <= 1'b1;
      cs_q        <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_idx_q  <= byte_idx_d;
      init_done_q <= init_done_d;
      oled_rst_q  <= oled_rst_d;
      vccen_q     <= vccen_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      pix_q       <= pix_d;
      alive_q     <= 1'b1;
      active_q    <= active_d;
      sck_q       <= sck_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      dc_q        <= dc_d;
      cs_q        <= cs_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign init_rom_addr = byte_idx_q[AW-1:0];
  assign init_done     = init_done_q;
  assign busy          = (state_q != S_IDLE) || !fifo_empty;
  assign spi_cs        = cs_q;
  assign spi_dc        = dc_q;
  assign spi_mosi      = shift_q[7];
  assign spi_sck       = sck_q;
  assign oled_rst      = oled_rst_q;
  assign vccen         = vccen_q;
  assign pmoden        = 1'b1;

endmodule

// File: tb/tb_oled_spi_engine.sv
// Testbench for oled_spi_engine: decodes the SPI pins into bytes and checks
// init, raw FIFO, window, pixel, arbitration and mid-burst reset behaviour.
module tb_oled_spi_engine;

  localparam int INIT_LEN = 45;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [5:0]  init_rom_addr;
  logic [7:0]  init_rom_data;
  logic        win_valid = 1'b0, win_ready;
  logic [7:0]  win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_dc = 1'b0;
  logic [7:0]  cmd_data = '0;
  logic        pix_valid = 1'b0, pix_ready;
  logic [15:0] pix_data = '0;
  logic        init_done, busy;
  logic [4:0]  fifo_level;
  logic        spi_cs, spi_dc, spi_mosi, spi_sck, oled_rst, vccen, pmoden;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [5:0] a);
    logic [7:0] r;
    r = {2'b00, a};
    return r * 8'd37 + 8'd5;
  endfunction

  assign init_rom_data = rom_val(init_rom_addr);

  oled_spi_engine #(
    .SYSTEM_CLK(50_000_000), .SPI_TRANSFER_RATE(25_000_000), .FIFO_DEPTH(16),
    .PIXEL_BYTES(2), .INIT_LEN(INIT_LEN), .RST_HOLD_CYCLES(16), .CS_GAP_CYCLES(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .init_rom_addr(init_rom_addr), .init_rom_data(init_rom_data),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dc(cmd_dc), .cmd_data(cmd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .init_done(init_done), .busy(busy), .fifo_level(fifo_level),
    .spi_cs(spi_cs), .spi_dc(spi_dc), .spi_mosi(spi_mosi), .spi_sck(spi_sck),
    .oled_rst(oled_rst), .vccen(vccen), .pmoden(pmoden)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // ---------------- SPI byte monitor ----------------
  typedef struct {
    int         txn;
    logic       dc;
    logic [7:0] data;
  } mon_t;

  mon_t mon_q[$];
  int   txn_id = 0;
  int   bitc = 0;
  logic [7:0] sh = '0;
  logic dcv = 1'b0;
  int   dc_unstable = 0;

  always @(negedge spi_cs) begin
    txn_id++;
    bitc = 0;
  end

  always @(posedge spi_sck) begin
    if (!spi_cs) begin
      if (bitc == 0) dcv = spi_dc;
      else if (spi_dc !== dcv) dc_unstable++;
      sh = {sh[6:0], spi_mosi};
      bitc++;
      if (bitc == 8) begin
        mon_q.push_back('{txn: txn_id, dc: dcv, data: sh});
        bitc = 0;
      end
    end
  end

  // CS low length per transaction and smallest CS-high gap between them.
  int cs_len_q[$];
  int low_cnt = 0, high_cnt = 0, min_gap = 1000;
  bit seen_txn = 1'b0;
  int win_pulses = 0, pix_pulses = 0;

  always @(negedge clk) begin
    if (win_ready) win_pulses++;
    if (pix_ready) pix_pulses++;
    if (!resetn) begin
      low_cnt  = 0;
      high_cnt = 0;
      seen_txn = 1'b0;
    end else if (!spi_cs) begin
      if (low_cnt == 0 && seen_txn && high_cnt < min_gap) min_gap = high_cnt;
      low_cnt++;
      high_cnt = 0;
    end else begin
      if (low_cnt > 0) begin
        cs_len_q.push_back(low_cnt);
        low_cnt  = 0;
        high_cnt = 0;
        seen_txn = 1'b1;
      end
      high_cnt++;
    end
  end

  function automatic mon_t mk(input int t, input logic d, input logic [7:0] v);
    mon_t m;
    m.txn = t; m.dc = d; m.data = v;
    return m;
  endfunction

  task automatic check_stream(input string name, input mon_t exp[$]);
    int t0;
    logic [31:0] a, e;
    t0 = 0;
    check({name, "_count"}, mon_q.size(), exp.size());
    if (mon_q.size() > 0) t0 = mon_q[0].txn;
    for (int i = 0; i < exp.size() && i < mon_q.size(); i++) begin
      a = {16'(mon_q[i].txn - t0), 7'd0, mon_q[i].dc, mon_q[i].data};
      e = {16'(exp[i].txn), 7'd0, exp[i].dc, exp[i].data};
      check($sformatf("%s_byte%0d", name, i), a, e);
    end
  endtask

  task automatic check_cs_len(input string name, input int idx, input int exp);
    int v;
    v = (cs_len_q.size() > idx) ? cs_len_q[idx] : -1;
    check(name, v, exp);
  endtask

  task automatic clear_mon();
    mon_q.delete();
    cs_len_q.delete();
    win_pulses = 0;
    pix_pulses = 0;
    min_gap = 1000;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cs"}, spi_cs, 1);
    check({tag, "_dc"}, spi_dc, 1);
    check({tag, "_sck"}, spi_sck, 0);
    check({tag, "_mosi"}, spi_mosi, 0);
    check({tag, "_oled_rst"}, oled_rst, 0);
    check({tag, "_vccen"}, vccen, 0);
    check({tag, "_pmoden"}, pmoden, 1);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_win_ready"}, win_ready, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_fifo_level"}, fifo_level, 0);
    check({tag, "_rom_addr"}, init_rom_addr, 0);
  endtask

  // Wait for the engine to start, then to return to IDLE with an empty FIFO.
  task automatic wait_idle(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (busy) begin got = 1'b1; break; end
    end
    if (got) begin
      got = 1'b0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk);
        if (!busy) begin got = 1'b1; break; end
      end
    end
    if (!got) check({name, "_timeout"}, 0, 1);
  endtask

  // Stream n pixels from pix_tab with pix_valid held; returns after the last accept.
  logic [15:0] pix_tab [3];

  task automatic send_pixels(input int n);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    pix_valid = 1'b1;
    pix_data  = pix_tab[0];
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pix_ready) k++;
      @(posedge clk); #1;
      if (k == n) begin done = 1'b1; break; end
      pix_data = pix_tab[k];
    end
    pix_valid = 1'b0;
    if (!done) check("pixel_source_timeout", 0, 1);
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    logic       dc;
    logic [7:0] data;
    logic       exp_ready;
    logic [4:0] exp_level;
  } push_vec_t;

  push_vec_t pushes [17];
  mon_t      exp_q[$];

  initial begin
    int  lowc;
    bit  got;

    for (int i = 0; i < 17; i++) begin
      pushes[i].dc        = i[0];
      pushes[i].data      = 8'hA0 + 8'(i);
      pushes[i].exp_ready = (i < 16);
      pushes[i].exp_level = (i < 16) ? 5'(i + 1) : 5'd16;
    end
    pix_tab[0] = 16'hF800;
    pix_tab[1] = 16'h07E0;
    pix_tab[2] = 16'h001F;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");

    // oled_rst hold length after release
    @(posedge clk); #1;
    resetn = 1'b1;
    lowc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (oled_rst) break;
      lowc++;
    end
    check("rst_hold_cycles", lowc, 16);
    check("vccen_after_hold", vccen, 1);

    // Fill the FIFO during init, one push too many
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      cmd_valid = 1'b1;
      cmd_dc    = pushes[i].dc;
      cmd_data  = pushes[i].data;
      @(negedge clk);
      check($sformatf("push%0d_ready", i), cmd_ready, pushes[i].exp_ready);
      @(posedge clk); #1;
      check($sformatf("push%0d_level", i), fifo_level, pushes[i].exp_level);
    end
    cmd_valid = 1'b0;

    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (init_done) begin got = 1'b1; break; end
    end
    check("init_done_rises", got, 1);
    wait_idle("raw_after_init");

    exp_q.delete();
    for (int i = 0; i < INIT_LEN; i++) exp_q.push_back(mk(0, 1'b0, rom_val(6'(i))));
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(1, pushes[i].dc, pushes[i].data));
    check_stream("init_raw", exp_q);
    check_cs_len("init_cs_low", 0, 720);
    check_cs_len("raw_cs_low", 1, 256);
    check("fifo_empty_after_raw", fifo_level, 0);
    clear_mon();

    // Window request
    @(posedge clk); #1;
    win_x0 = 8'd0; win_x1 = 8'd95; win_y0 = 8'd0; win_y1 = 8'd63;
    win_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (win_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    win_valid = 1'b0;
    check("win_accepted", got, 1);
    wait_idle("window");
    exp_q.delete();
    exp_q.push_back(mk(0, 1'b0, 8'h15));
    exp_q.push_back(mk(0, 1'b0, 8'h00));
    exp_q.push_back(mk(0, 1'b0, 8'h5F));
    exp_q.push_back(mk(0, 1'b0, 8'h75));
    exp_q.push_back(mk(0, 1'b0, 8'h00));
    exp_q.push_back(mk(0, 1'b0, 8'h3F));
    check_stream("window", exp_q);
    check("win_ready_pulses", win_pulses, 1);
    clear_mon();

    // Three-pixel burst
    @(posedge clk); #1;
    send_pixels(3);
    wait_idle("pixels");
    exp_q.delete();
    exp_q.push_back(mk(0, 1'b1, 8'hF8));
    exp_q.push_back(mk(0, 1'b1, 8'h00));
    exp_q.push_back(mk(0, 1'b1, 8'h07));
    exp_q.push_back(mk(0, 1'b1, 8'hE0));
    exp_q.push_back(mk(0, 1'b1, 8'h00));
    exp_q.push_back(mk(0, 1'b1, 8'h1F));
    check_stream("pixels", exp_q);
    check_cs_len("pixel_cs_low", 0, 96);
    check("pix_ready_pulses", pix_pulses, 3);
    clear_mon();

    // All three channels requested together in IDLE
    @(posedge clk); #1;
    win_x0 = 8'h02; win_x1 = 8'h11; win_y0 = 8'h03; win_y1 = 8'h22;
    win_valid = 1'b1;
    cmd_valid = 1'b1; cmd_dc = 1'b1; cmd_data = 8'h5A;
    pix_valid = 1'b1; pix_data = 16'h1234;
    @(posedge clk); #1;
    win_valid = 1'b0;
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pix_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    check("prio_pixel_accepted", got, 1);
    wait_idle("priority");
    exp_q.delete();
    exp_q.push_back(mk(0, 1'b0, 8'h15));
    exp_q.push_back(mk(0, 1'b0, 8'h02));
    exp_q.push_back(mk(0, 1'b0, 8'h11));
    exp_q.push_back(mk(0, 1'b0, 8'h75));
    exp_q.push_back(mk(0, 1'b0, 8'h03));
    exp_q.push_back(mk(0, 1'b0, 8'h22));
    exp_q.push_back(mk(1, 1'b1, 8'h5A));
    exp_q.push_back(mk(2, 1'b1, 8'h12));
    exp_q.push_back(mk(2, 1'b1, 8'h34));
    check_stream("priority", exp_q);
    check("prio_win_pulses", win_pulses, 1);
    check("prio_cs_gap_at_least_2", (min_gap >= 2) && (min_gap < 1000), 1);
    clear_mon();

    // Reset in the middle of a pixel burst with FIFO entries pending
    @(posedge clk); #1;
    pix_data  = 16'hABCD;
    pix_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!spi_cs) begin got = 1'b1; break; end
    end
    check("burst_started", got, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dc = 1'b0; cmd_data = 8'h11;
    @(posedge clk); #1;
    cmd_data = 8'h22;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("fifo_level_before_abort", fifo_level, 2);
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_reset_state("midreset");
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    clear_mon();
    @(posedge clk); #1;
    resetn = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (init_done) begin got = 1'b1; break; end
    end
    check("reinit_done", got, 1);
    repeat (40) @(negedge clk);
    check("reinit_busy", busy, 0);
    check("reinit_fifo_level", fifo_level, 0);
    exp_q.delete();
    for (int i = 0; i < INIT_LEN; i++) exp_q.push_back(mk(0, 1'b0, rom_val(6'(i))));
    check_stream("reinit", exp_q);
    check("dc_stable_within_bytes", dc_unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
